// File: rtl/uart_baud_gen_prog_if.sv
// uart_baud_gen_prog_if: config and tick bundle between the register block (master) and the baud generator (slave).
// Signals: enable, cfg_div_int/cfg_div_frac/cfg_os16/cfg_load (to generator); cfg_pending, rx_tick, tx_tick (from generator).
interface uart_baud_gen_prog_if #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
);
    logic              enable;
    logic [DIV_W-1:0]  cfg_div_int;
    logic [FRAC_W-1:0] cfg_div_frac;
    logic              cfg_os16;
    logic              cfg_load;
    logic              cfg_pending;
    logic              rx_tick;
    logic              tx_tick;
    modport master (
        output enable, cfg_div_int, cfg_div_frac, cfg_os16, cfg_load,
        input  cfg_pending, rx_tick, tx_tick
    );
    modport slave (
        input  enable, cfg_div_int, cfg_div_frac, cfg_os16, cfg_load,
        output cfg_pending, rx_tick, tx_tick
    );
endinterface

// File: rtl/uart_baud_gen_prog.sv
// uart_baud_gen_prog: runtime-programmable UART baud tick generator (rx oversample tick, tx bit tick).
// Ports: clk, reset (sync, active high), bus (slave modport: enable, cfg_* in; cfg_pending, rx_tick, tx_tick out).
// Build option: define UART_BAUD_FRAC_EN to include the fractional divisor accumulator.
module uart_baud_gen_prog #(
    parameter int SYSTEM_CLK   = 100000000,
    parameter int BAUD_RATE    = 9600,
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 4,
    parameter bit DEFAULT_OS16 = 1'b0,
    parameter int DEFAULT_DIV  = (SYSTEM_CLK / (BAUD_RATE * 8)) % (2 ** DIV_W)
) (
    input logic                 clk,
    input logic                 reset,
    uart_baud_gen_prog_if.slave bus
);
    localparam logic [DIV_W-1:0] DEF_T   = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] RST_DIV = (DEF_T < DIV_W'(2)) ? DIV_W'(2) : DEF_T;
    logic [DIV_W-1:0] d_a_q, d_s_q, cnt_q;
    logic             os16_a_q, os16_s_q, pend_q, rx_q, tx_q;
    logic [3:0]       os_cnt_q;
    logic [DIV_W:0]   last;
    logic             extra, wrap, apply, os_wrap;
    // One extra bit so D_a + extra cannot overflow when D_a is at its maximum.
    assign last    = {1'b0, d_a_q} + (DIV_W+1)'(extra) - (DIV_W+1)'(1);
    assign wrap    = bus.enable && ({1'b0, cnt_q} == last);
    // Disabled: a pending load applies on the very next edge.
    assign apply   = pend_q && (wrap || !bus.enable);
    assign os_wrap = os_cnt_q == (os16_a_q ? 4'd15 : 4'd7);
    always_ff @(posedge clk) begin
        if (reset) begin
            d_a_q    <= RST_DIV;
            d_s_q    <= RST_DIV;
            os16_a_q <= DEFAULT_OS16;
            os16_s_q <= DEFAULT_OS16;
            pend_q   <= 1'b0;
            cnt_q    <= '0;
            os_cnt_q <= '0;
            rx_q     <= 1'b0;
            tx_q     <= 1'b0;
        end else begin
            if (bus.cfg_load) begin
                d_s_q    <= (bus.cfg_div_int < DIV_W'(2)) ? DIV_W'(2) : bus.cfg_div_int;
                os16_s_q <= bus.cfg_os16;
            end
            // The apply at this edge uses the old shadow; a same-cycle load stays pending.
            if (apply) begin
                d_a_q    <= d_s_q;
                os16_a_q <= os16_s_q;
            end
            pend_q   <= bus.cfg_load || (pend_q && !apply);
            cnt_q    <= (!bus.enable || wrap) ? '0 : cnt_q + DIV_W'(1);
            os_cnt_q <= (!bus.enable || apply) ? '0 : !wrap ? os_cnt_q : os_wrap ? '0 : os_cnt_q + 4'd1;
            rx_q     <= wrap;
            tx_q     <= wrap && os_wrap;
        end
    end
`ifdef UART_BAUD_FRAC_EN
    logic [FRAC_W-1:0] f_a_q, f_s_q, acc_q;
    logic [FRAC_W:0]   sum;
    logic              extra_q;
    assign sum   = {1'b0, acc_q} + {1'b0, f_a_q};
    assign extra = extra_q;
    // Carry out of the accumulator lengthens the following period by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            f_a_q   <= '0;
            f_s_q   <= '0;
            acc_q   <= '0;
            extra_q <= 1'b0;
        end else begin
            if (bus.cfg_load) f_s_q <= bus.cfg_div_frac;
            if (apply) f_a_q <= f_s_q;
            acc_q   <= (!bus.enable || apply) ? '0 : wrap ? sum[FRAC_W-1:0] : acc_q;
            extra_q <= (!bus.enable || apply) ? 1'b0 : wrap ? sum[FRAC_W] : extra_q;
        end
    end
`else
    assign extra = 1'b0;
`endif
    assign bus.cfg_pending = pend_q;
    assign bus.rx_tick     = rx_q;
    assign bus.tx_tick     = tx_q;
endmodule

// File: tb/tb_uart_baud_gen_prog.sv
// tb_uart_baud_gen_prog: directed bench with a closed-form tick-time model plus literal timing checks.
module tb_uart_baud_gen_prog;
    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;
    localparam int RST_D  = 1302;
`ifdef UART_BAUD_FRAC_EN
    localparam bit FRAC_ON = 1'b1;
`else
    localparam bit FRAC_ON = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0, errors = 0, cyc = 0;
    uart_baud_gen_prog_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) bus ();
    uart_baud_gen_prog dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Model: within a segment (started by reset, enable rise or apply) the n-th tick lands
    // n*D + floor((n-1)*F/2^FRAC_W) enabled edges after the segment start; tx on every OS-th tick.
    int md = RST_D, mf = 0, sd = RST_D, sf = 0, el = 0, n = 0;
    bit mos = 1'b0, sos = 1'b0, mpend = 1'b0, exp_rx = 1'b0, exp_tx = 1'b0, started = 1'b0, hit;
    always @(posedge clk) begin
        started = 1'b1;
        exp_rx  = 1'b0;
        exp_tx  = 1'b0;
        hit     = 1'b0;
        if (reset) begin
            md = RST_D; mf = 0; sd = RST_D; sf = 0; mos = 1'b0; sos = 1'b0; mpend = 1'b0; el = 0; n = 0;
        end else begin
            if (bus.enable) begin
                el++;
                if (el == (n + 1) * md + ((n * mf) >> FRAC_W)) begin
                    n++;
                    exp_rx = 1'b1;
                    exp_tx = (n % (mos ? 16 : 8)) == 0;
                    hit    = 1'b1;
                end
            end else begin
                el = 0;
                n  = 0;
            end
            if (mpend && (hit || !bus.enable)) begin
                md = sd; mf = sf; mos = sos; mpend = 1'b0; el = 0; n = 0;
            end
            if (bus.cfg_load) begin
                sd    = (bus.cfg_div_int < 2) ? 2 : int'(bus.cfg_div_int);
                sf    = FRAC_ON ? int'(bus.cfg_div_frac) : 0;
                sos   = bus.cfg_os16;
                mpend = 1'b1;
            end
        end
    end
    always @(negedge clk) begin
        if (started) begin
            checks += 3;
            if (bus.rx_tick !== exp_rx) begin
                errors++;
                $display("FAIL rx_tick cycle %0d: got %b want %b", cyc, bus.rx_tick, exp_rx);
            end
            if (bus.tx_tick !== exp_tx) begin
                errors++;
                $display("FAIL tx_tick cycle %0d: got %b want %b", cyc, bus.tx_tick, exp_tx);
            end
            if (bus.cfg_pending !== mpend) begin
                errors++;
                $display("FAIL cfg_pending cycle %0d: got %b want %b", cyc, bus.cfg_pending, mpend);
            end
        end
    end
    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask
    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask
    task automatic load(input int d, input int f, input bit os);
        bus.cfg_div_int  = DIV_W'(d);
        bus.cfg_div_frac = FRAC_W'(f);
        bus.cfg_os16     = os;
        bus.cfg_load     = 1'b1;
        @(negedge clk);
        bus.cfg_load     = 1'b0;
    endtask
    task automatic wait_rx(output int t);
        t = -1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (bus.rx_tick === 1'b1) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) chk("rx_timeout", 0, 1);
    endtask
    task automatic wait_tx(output int t);
        t = -1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (bus.tx_tick === 1'b1) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) chk("tx_timeout", 0, 1);
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
    initial begin
        int t0, t1, t2, a, b, c, d, ntx, bad, txi, cnt;
        int tt[17];
        bus.enable = 1'b0; bus.cfg_div_int = '0; bus.cfg_div_frac = '0; bus.cfg_os16 = 1'b0; bus.cfg_load = 1'b0;
        step(3);
        reset = 1'b0;
        chk("reset_rx", int'(bus.rx_tick), 0);
        chk("reset_tx", int'(bus.tx_tick), 0);
        chk("reset_pending", int'(bus.cfg_pending), 0);
        // 1: D=4, 8x
        load(4, 0, 1'b0);
        step(2);
        bus.enable = 1'b1; t0 = cyc;
        wait_rx(t1); chk("t1_first_rx", t1 - t0, 4);
        wait_rx(t2); chk("t1_rx_period", t2 - t1, 4);
        wait_tx(a);  chk("t1_first_tx", a - t0, 32);
        wait_tx(b);  chk("t1_tx_period", b - a, 32);
        // 2: D=4, F=0.5, 16x
        bus.enable = 1'b0;
        load(4, 8, 1'b1);
        step(2);
        bus.enable = 1'b1; t0 = cyc; ntx = 0; bad = 0;
        for (int k = 0; k < 17; k++) begin
            wait_rx(tt[k]);
            if (bus.tx_tick === 1'b1) ntx++;
            if (k > 0 && (tt[k] - tt[k-1] < 4 || tt[k] - tt[k-1] > (FRAC_ON ? 5 : 4))) bad++;
        end
        chk("t2_first_rx", tt[0] - t0, 4);
        chk("t2_span_16", tt[16] - tt[0], FRAC_ON ? 72 : 64);
        chk("t2_period_range", bad, 0);
        chk("t2_tx_count", ntx, 1);
        // 3: D=10 running, load D=3 mid-period
        bus.enable = 1'b0;
        load(10, 0, 1'b0);
        step(2);
        bus.enable = 1'b1; t0 = cyc;
        wait_rx(a); chk("t3_first_rx", a - t0, 10);
        step(4);
        load(3, 0, 1'b0);
        chk("t3_pending_set", int'(bus.cfg_pending), 1);
        wait_rx(b); chk("t3_old_period", b - a, 10);
        chk("t3_pending_clear", int'(bus.cfg_pending), 0);
        wait_rx(c); chk("t3_new_period", c - b, 3);
        wait_rx(d); chk("t3_new_period2", d - c, 3);
        // 4: clamp of D=0 and D=1
        load(0, 0, 1'b0);
        wait_rx(a); wait_rx(b); wait_rx(c);
        chk("t4_d0_period", c - b, 2);
        load(1, 0, 1'b0);
        wait_rx(a); wait_rx(b); wait_rx(c);
        chk("t4_d1_period", c - b, 2);
        // 5: enable dropped mid-period with D=6
        load(6, 0, 1'b0);
        wait_rx(a); wait_rx(b);
        step(3);
        bus.enable = 1'b0; cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rx_tick === 1'b1) cnt++;
        end
        chk("t5_no_ticks_disabled", cnt, 0);
        bus.enable = 1'b1; t0 = cyc;
        wait_rx(a); chk("t5_first_rx", a - t0, 6);
        txi = (bus.tx_tick === 1'b1) ? 1 : 0;
        for (int k = 2; k <= 9 && txi == 0; k++) begin
            wait_rx(a);
            if (bus.tx_tick === 1'b1) txi = k;
        end
        chk("t5_tx_on_8th", txi, 8);
        // 6: reset with load pending mid-period
        load(3, 0, 1'b0);
        step(1);
        chk("t6_pending_before", int'(bus.cfg_pending), 1);
        reset = 1'b1;
        step(1);
        chk("t6_reset_pending", int'(bus.cfg_pending), 0);
        chk("t6_reset_rx", int'(bus.rx_tick), 0);
        reset = 1'b0; t0 = cyc;
        wait_rx(a); chk("t6_default_period", a - t0, RST_D);
        chk("t6_pending_after", int'(bus.cfg_pending), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_baud_gen_prog.md
# uart_baud_gen_prog

- Runtime-programmable baud tick generator for the UART transmitter and receiver; successor to the fixed-parameter baud generator.
- Produces a receiver oversample tick (`rx_tick`) and a transmitter bit tick (`tx_tick`) from the system clock.
- Divisor, fractional trim and oversample ratio (8x/16x) are reprogrammable at run time, with glitch-free switchover at tick boundaries.
- Sits between the register interface and the `uart_tx`/`uart_rx` engines.

## Interface
Parameters:
- `SYSTEM_CLK`, 100000000, system clock frequency in Hz; used only for reset defaults.
- `BAUD_RATE`, 9600, reset-default baud rate.
- `DIV_W`, 16, integer divisor width.
- `FRAC_W`, 4, fractional divisor width.
- `DEFAULT_OS16`, 0, reset oversample mode: 0 = 8x, 1 = 16x.
- `DEFAULT_DIV`, `SYSTEM_CLK/(BAUD_RATE*8)` truncated to `DIV_W` bits, reset integer divisor.

Ports (clock and reset first):
- `clk`  in  1  system clock; the block's only clock.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  run/stop for tick generation.
- `cfg_div_int`  in  `DIV_W`  integer divisor D, in clk cycles per oversample tick.
- `cfg_div_frac`  in  `FRAC_W`  fractional divisor F, in units of 1/2^`FRAC_W`.
- `cfg_os16`  in  1  oversample select: 0 = 8x, 1 = 16x.
- `cfg_load`  in  1  one-cycle strobe that captures the three `cfg_*` fields.
- `cfg_pending`  out  1  captured config not yet applied.
- `rx_tick`  out  1  one-cycle oversample tick.
- `tx_tick`  out  1  one-cycle bit tick; always coincident with an `rx_tick`.

## Operation
Registers:
- Active config: `D_a`, `F_a`, `os16_a`.
- Shadow config: `D_s`, `F_s`, `os16_s`.
- Period counter `cnt` (`DIV_W` bits).
- Fraction accumulator `acc` (`FRAC_W` bits).
- Oversample counter `os_cnt` (4 bits).
- Flag `extra`.

Period generation:
- Current period length is P = `D_a` + `extra`.
- Each enabled cycle `cnt` increments. When `cnt` == P−1, `cnt` returns to 0 and `rx_tick` is registered high for the following cycle.
- At each `rx_tick` event, `acc` ← `acc` + `F_a`. The carry-out of that add becomes `extra` for the next period.
- Average period is therefore D + F/2^`FRAC_W`.

Bit tick:
- `os_cnt` counts `rx_tick` events 0..OS−1, where OS = 8 or 16.
- `tx_tick` is asserted on the same cycle as the `rx_tick` whose event wraps `os_cnt` from OS−1 to 0.

Configuration load:
- `cfg_load` writes the shadow registers and sets `cfg_pending`.
- Shadow is copied to active at the next period boundary, i.e. the cycle `cnt` wraps.
- On apply: `acc`, `os_cnt` and `extra` clear, `cfg_pending` clears, and the next period uses the new `D_a`.
- While `enable` = 0, a pending load applies on the next cycle.

Divisor clamp:
- Loaded `cfg_div_int` < 2 is clamped to 2, so the minimum period is 2 cycles.

Enable:
- `enable` = 0 forces `cnt`, `acc`, `os_cnt` and `extra` to 0 and holds both ticks low.
- The active config and shadow registers are retained while disabled.

Boundary conditions:
- `cfg_load` while `cfg_pending` = 1: shadow is overwritten; only the last load applies.
- `cfg_load` on the same cycle as a boundary: the boundary applies the old shadow contents (if pending). The new values are applied at the next boundary.
- `enable` falling on the cycle a tick would be registered: the tick is suppressed.
- `reset` at any point, including mid-period or with a load pending, returns all state to reset values next edge. The pending load is discarded.

## Timing
Reset values:
- `rx_tick` = 0, `tx_tick` = 0, `cfg_pending` = 0.
- `D_a` = `D_s` = max(`DEFAULT_DIV`, 2); `F_a` = `F_s` = 0; `os16_a` = `os16_s` = `DEFAULT_OS16`.
- `cnt` = `acc` = `os_cnt` = `extra` = 0.

Cycle-level behaviour:
- Ticks are registered outputs, high for exactly 1 cycle.
- The first `rx_tick` is high in the cycle after the D-th enabled rising edge following reset release or an `enable` rise.
- `cfg_pending` rises in the cycle after `cfg_load` is sampled.
- `cfg_pending` falls in the cycle after the apply edge.
- The first tick using the new config arrives P_new cycles after the apply edge.

## Configuration
Macro `UART_BAUD_FRAC_EN`:
- Defined: fractional accumulator present; behaviour as above.
- Undefined: `acc`, `extra` and `F_s`/`F_a` are not built and `cfg_div_frac` is ignored. Every period is exactly `D_a` cycles.

## Test plan
1. D=4, F=0, 8x, `enable`=1 after reset → `rx_tick` every 4 cycles (first after the 4th edge); `tx_tick` every 32 cycles, aligned to every 8th `rx_tick`.
2. `UART_BAUD_FRAC_EN` defined, D=4, F=8 (0.5), 16x → exactly 72 cycles over 16 `rx_tick`s; periods only 4 or 5; exactly 1 `tx_tick` per 16 `rx_tick`s.
3. D=10 running; load D=3 at cycle 5 of a period → current period still ends at 10 cycles, then periods of 3; `cfg_pending` high from the cycle after the load through the apply edge.
4. Load D=0 and, separately, D=1 → `rx_tick` every 2 cycles in both cases.
5. `enable` dropped mid-period for 20 cycles with D=6 → no ticks while low; after re-enable the first `rx_tick` arrives after 6 edges, and `os_cnt` restarts so `tx_tick` falls on the 8th `rx_tick`.
6. `reset` pulsed with a load pending and `cnt` mid-period → all outputs 0; next run uses `DEFAULT_DIV`; `cfg_pending` stays 0.
